rv_mc_ctl: RTL and testbench
============================

# rv_mc_ctl

Parametrised multicycle RISC-V control plane: next generation of the single-FSM controller. It drives the same multicycle datapath and adds:
- a variable-latency memory handshake with a timeout;
- extra instructions (BNE, BLT, JALR, LUI, proper ADDI);
- a trap path for illegal instructions and bus timeouts;
- a retired-instruction counter.

It sits between the shared instruction/data memory port and the datapath.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter
- MEM_WAIT_MAX, 15, max wait cycles per memory access before bus-timeout trap; 0 disables timeout
- TRAP_EN, 1, 1: illegal/timeout go to TRAP; 0: illegal instr skipped (back to FETCH), timeout disabled

Ports (clock and reset first):
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- instr  in  32  current IR contents
- zero  in  1  ALU result == 0
- lt  in  1  ALU signed less-than (rs1 < rs2)
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory request valid
- memrw  out  1  1 = write (SW), 0 = read
- pcsource  out  2  PC_INC / PC_ALU (live ALU) / PC_ALUOUT (registered) / PC_TRAP
- pcwrite, pccen, irwrite, mdrwrite, regwen  out  1 each  datapath write enables
- wbsel  out  2  WB_PC / WB_ALUOUT / WB_MDR
- immsel  out  3  IMM_B / IMM_L / IMM_S / IMM_J / IMM_U
- asel, bsel  out  2 each  ALUA_REG/PCC/ZERO, ALUB_REG/IMM
- alusel  out  4  params.inc ALU codes
- trap  out  1  high for the single TRAP cycle
- trap_cause  out  2  registered; 0 none, 1 illegal instr, 2 bus timeout
- state  out  4  current state encoding (debug)
- instr_count  out  CNT_W  retired instructions, wraps

## Operation
- States (encoding): IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, LW_MEM=4, LW_WB=5, SW_MEM=6, RTYPE_ALU=7, ITYPE_ALU=8, ALU_WB=9, BR_EXEC=10, JAL_EXEC=11, JALR_EXEC=12, LUI_EXEC=13, TRAP=14.
- Defaults (all states): all enables 0, mem_req 0, pcsource PC_INC, wbsel WB_PC, immsel IMM_B, asel ALUA_REG, bsel ALUB_REG, alusel ALU_ADD.
- IDLE:
  - outputs at defaults;
  - next state FETCH.
- FETCH:
  - mem_req=1, memrw=0;
  - when mem_ready: irwrite, pcwrite, pccen = 1, next state DECODE;
  - otherwise stay in FETCH.
- DECODE:
  - computes branch target PCC+IMM_B into ALUOut;
  - next state by opcode/funct3: LW/SW → MEM_ADDR; R-type → RTYPE_ALU; ADDI → ITYPE_ALU; BEQ/BNE/BLT → BR_EXEC; JAL → JAL_EXEC; JALR → JALR_EXEC; LUI → LUI_EXEC;
  - any other opcode → TRAP (cause 1) if TRAP_EN, else FETCH.
- MEM_ADDR:
  - REG+imm, with immsel IMM_L for LW and IMM_S for SW;
  - next state LW_MEM or SW_MEM.
- LW_MEM:
  - mem_req=1;
  - on mem_ready: mdrwrite=1, next state LW_WB.
- LW_WB: wbsel WB_MDR, regwen=1.
- SW_MEM: mem_req=1, memrw=1; on mem_ready, next state FETCH.
- RTYPE_ALU: alusel={funct3, instr[30]}.
- ITYPE_ALU: bsel IMM, immsel IMM_L, alusel={funct3,1'b0}.
- ALU_WB: wbsel WB_ALUOUT, regwen=1.
- BR_EXEC:
  - ALU_SUB on REG/REG, pcsource PC_ALUOUT;
  - pcwrite = zero (BEQ), !zero (BNE), lt (BLT).
- JAL_EXEC:
  - asel PCC, bsel IMM, immsel IMM_J, pcsource PC_ALU;
  - pcwrite=1, regwen=1, wbsel WB_PC.
- JALR_EXEC: as JAL_EXEC but asel REG, immsel IMM_L.
- LUI_EXEC: asel ZERO, bsel IMM, immsel IMM_U; next state ALU_WB.
- TRAP:
  - trap=1, pcsource PC_TRAP, pcwrite=1;
  - next state FETCH.
- trap_cause:
  - loaded on entry to TRAP;
  - holds until the next trap or reset.
- instr_count:
  - increments on every transition into FETCH from LW_WB, SW_MEM, ALU_WB, BR_EXEC, JAL_EXEC or JALR_EXEC;
  - TRAP and skipped illegal instructions do not count;
  - wraps at 2^CNT_W.

## Timing
- Reset: state IDLE, trap_cause 0, instr_count 0, wait counter 0. All outputs are at defaults while rst is high. The first mem_req occurs one cycle after rst deasserts.
- Reset mid-access aborts immediately (asynchronous); no write enable is asserted in the reset cycle.
- Wait counter:
  - counts cycles with mem_req=1 and mem_ready=0;
  - cleared on every state change.
- Timeout:
  - if mem_ready=0 while the counter equals MEM_WAIT_MAX (nonzero, TRAP_EN=1), next state is TRAP with cause 2, so at most MEM_WAIT_MAX+1 wait cycles;
  - mem_ready high in the limit cycle wins, and the access completes normally.
- Latency with mem_ready tied high: LW 5, SW 4, R/ADDI/LUI 4, branches/JAL/JALR 3 cycles; TRAP adds 1.
- Branch not taken: PC keeps PC+4 from FETCH.
- JALR with rd==rs1: the target uses the pre-write rs1.

## Test plan
- Reset, then mem_ready=1 and LW x1,4(x0) → state sequence 0,1,2,3,4,5,1; mdrwrite in state 4, regwen in state 5; instr_count=1.
- BNE with zero=0, then BNE with zero=1 → first: pcwrite=1, pcsource=PC_ALUOUT in BR_EXEC; second: pcwrite=0; instr_count +2.
- FETCH with mem_ready low 3 cycles, MEM_WAIT_MAX=15 → mem_req held 4 cycles, irwrite only in the 4th.
- mem_ready held low, MEM_WAIT_MAX=15 → TRAP entered after 16 wait cycles; trap=1 for 1 cycle, trap_cause=2, pcsource=PC_TRAP, instr_count unchanged.
- Opcode 7'h0F in DECODE: TRAP_EN=1 → TRAP with cause 1. TRAP_EN=0 → back to FETCH, count unchanged.
- rst pulsed during LW_MEM wait → state 0 immediately, mem_req=0, instr_count=0, no mdrwrite.

Source files
------------

// File: rtl/rv_mc_ctl_if.sv
// Shared instruction/data memory handshake between the controller and the memory port.
// The controller raises mem_req (with memrw) and memory answers with mem_ready.
interface rv_mc_ctl_if;
    logic mem_req;
    logic memrw;
    logic mem_ready;

    modport master (output mem_req, output memrw, input mem_ready);
    modport slave  (input mem_req, input memrw, output mem_ready);
endinterface

// File: rtl/rv_mc_ctl.sv
// Multicycle RISC-V control FSM with memory wait/timeout handling, a trap path
// and a retired-instruction counter.
module rv_mc_ctl #(
    parameter int CNT_W        = 32,
    parameter int MEM_WAIT_MAX = 15,
    parameter bit TRAP_EN      = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    rv_mc_ctl_if.master      mem,
    input  logic [31:0]      instr,
    input  logic             zero,
    input  logic             lt,
    output logic [1:0]       pcsource,
    output logic             pcwrite,
    output logic             pccen,
    output logic             irwrite,
    output logic             mdrwrite,
    output logic             regwen,
    output logic [1:0]       wbsel,
    output logic [2:0]       immsel,
    output logic [1:0]       asel,
    output logic [1:0]       bsel,
    output logic [3:0]       alusel,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [1:0] PC_INC = 2'd0, PC_ALU = 2'd1, PC_ALUOUT = 2'd2, PC_TRAP = 2'd3;
    localparam logic [1:0] WB_PC = 2'd0, WB_ALUOUT = 2'd1, WB_MDR = 2'd2;
    localparam logic [2:0] IMM_B = 3'd0, IMM_L = 3'd1, IMM_S = 3'd2, IMM_J = 3'd3, IMM_U = 3'd4;
    localparam logic [1:0] ALUA_REG = 2'd0, ALUA_PCC = 2'd1, ALUA_ZERO = 2'd2;
    localparam logic [1:0] ALUB_REG = 2'd0, ALUB_IMM = 2'd1;
    localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001;

    localparam logic [6:0] OP_LOAD = 7'h03, OP_STORE = 7'h23, OP_REG = 7'h33, OP_IMM = 7'h13;
    localparam logic [6:0] OP_BRANCH = 7'h63, OP_JAL = 7'h6F, OP_JALR = 7'h67, OP_LUI = 7'h37;

    localparam bit TIMEOUT_EN = TRAP_EN && (MEM_WAIT_MAX != 0);
    localparam int WAIT_W     = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MEM_WAIT_MAX);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_LW_MEM    = 4'd4,
        S_LW_WB     = 4'd5,
        S_SW_MEM    = 4'd6,
        S_RTYPE_ALU = 4'd7,
        S_ITYPE_ALU = 4'd8,
        S_ALU_WB    = 4'd9,
        S_BR_EXEC   = 4'd10,
        S_JAL_EXEC  = 4'd11,
        S_JALR_EXEC = 4'd12,
        S_LUI_EXEC  = 4'd13,
        S_TRAP      = 4'd14
    } state_t;

    state_t            cur, nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_hit;
    logic              illegal;
    logic              retire_src;
    logic [1:0]        next_cause;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic              unused_instr_bits;

    assign opcode            = instr[6:0];
    assign funct3            = instr[14:12];
    assign state             = cur;
    assign wait_hit          = (wait_cnt == WAIT_LIM);
    assign retire_src        = cur inside {S_LW_WB, S_SW_MEM, S_ALU_WB, S_BR_EXEC, S_JAL_EXEC, S_JALR_EXEC};
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    // State register plus the wait counter, sticky trap cause and retire counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur         <= S_IDLE;
            wait_cnt    <= '0;
            trap_cause  <= 2'd0;
            instr_count <= '0;
        end else begin
            cur <= nxt;
            if (nxt != cur)
                wait_cnt <= '0;
            else if (mem.mem_req && !mem.mem_ready && !wait_hit)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            if (nxt == S_TRAP && cur != S_TRAP)
                trap_cause <= next_cause;
            if (nxt == S_FETCH && retire_src)
                instr_count <= instr_count + CNT_W'(1);
        end
    end

    // Next state and datapath controls; a timeout fires only when memory is still
    // not ready in the cycle the wait counter sits at its limit.
    always_comb begin
        nxt          = cur;
        mem.mem_req  = 1'b0;
        mem.memrw    = 1'b0;
        pcsource     = PC_INC;
        pcwrite      = 1'b0;
        pccen        = 1'b0;
        irwrite      = 1'b0;
        mdrwrite     = 1'b0;
        regwen       = 1'b0;
        wbsel        = WB_PC;
        immsel       = IMM_B;
        asel         = ALUA_REG;
        bsel         = ALUB_REG;
        alusel       = ALU_ADD;
        trap         = 1'b0;
        illegal      = 1'b0;
        next_cause   = 2'd0;

        case (cur)
            S_IDLE: nxt = S_FETCH;
            S_FETCH: begin
                mem.mem_req = 1'b1;
                if (mem.mem_ready) begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    pccen   = 1'b1;
                    nxt     = S_DECODE;
                end else if (TIMEOUT_EN && wait_hit) begin
                    nxt        = S_TRAP;
                    next_cause = 2'd2;
                end
            end
            S_DECODE: begin
                asel   = ALUA_PCC;
                bsel   = ALUB_IMM;
                immsel = IMM_B;
                case (opcode)
                    OP_LOAD, OP_STORE: nxt = S_MEM_ADDR;
                    OP_REG:            nxt = S_RTYPE_ALU;
                    OP_IMM:    if (funct3 == 3'b000) nxt = S_ITYPE_ALU; else illegal = 1'b1;
                    OP_BRANCH: if (funct3 inside {3'b000, 3'b001, 3'b100}) nxt = S_BR_EXEC;
                               else illegal = 1'b1;
                    OP_JAL:            nxt = S_JAL_EXEC;
                    OP_JALR:           nxt = S_JALR_EXEC;
                    OP_LUI:            nxt = S_LUI_EXEC;
                    default:           illegal = 1'b1;
                endcase
                if (illegal) begin
                    if (TRAP_EN) begin
                        nxt        = S_TRAP;
                        next_cause = 2'd1;
                    end else begin
                        nxt = S_FETCH;
                    end
                end
            end
            S_MEM_ADDR: begin
                bsel   = ALUB_IMM;
                immsel = opcode[5] ? IMM_S : IMM_L;
                nxt    = opcode[5] ? S_SW_MEM : S_LW_MEM;
            end
            S_LW_MEM: begin
                mem.mem_req = 1'b1;
                if (mem.mem_ready) begin
                    mdrwrite = 1'b1;
                    nxt      = S_LW_WB;
                end else if (TIMEOUT_EN && wait_hit) begin
                    nxt        = S_TRAP;
                    next_cause = 2'd2;
                end
            end
            S_LW_WB: begin
                wbsel  = WB_MDR;
                regwen = 1'b1;
                nxt    = S_FETCH;
            end
            S_SW_MEM: begin
                mem.mem_req = 1'b1;
                mem.memrw   = 1'b1;
                if (mem.mem_ready) begin
                    nxt = S_FETCH;
                end else if (TIMEOUT_EN && wait_hit) begin
                    nxt        = S_TRAP;
                    next_cause = 2'd2;
                end
            end
            S_RTYPE_ALU: begin
                alusel = {funct3, instr[30]};
                nxt    = S_ALU_WB;
            end
            S_ITYPE_ALU: begin
                bsel   = ALUB_IMM;
                immsel = IMM_L;
                alusel = {funct3, 1'b0};
                nxt    = S_ALU_WB;
            end
            S_ALU_WB: begin
                wbsel  = WB_ALUOUT;
                regwen = 1'b1;
                nxt    = S_FETCH;
            end
            S_BR_EXEC: begin
                alusel   = ALU_SUB;
                pcsource = PC_ALUOUT;
                case (funct3)
                    3'b000:  pcwrite = zero;
                    3'b001:  pcwrite = !zero;
                    3'b100:  pcwrite = lt;
                    default: pcwrite = 1'b0;
                endcase
                nxt = S_FETCH;
            end
            S_JAL_EXEC, S_JALR_EXEC: begin
                asel     = (cur == S_JAL_EXEC) ? ALUA_PCC : ALUA_REG;
                immsel   = (cur == S_JAL_EXEC) ? IMM_J : IMM_L;
                bsel     = ALUB_IMM;
                pcsource = PC_ALU;
                pcwrite  = 1'b1;
                regwen   = 1'b1;
                wbsel    = WB_PC;
                nxt      = S_FETCH;
            end
            S_LUI_EXEC: begin
                asel   = ALUA_ZERO;
                bsel   = ALUB_IMM;
                immsel = IMM_U;
                nxt    = S_ALU_WB;
            end
            S_TRAP: begin
                trap     = 1'b1;
                pcsource = PC_TRAP;
                pcwrite  = 1'b1;
                nxt      = S_FETCH;
            end
            default: nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_rv_mc_ctl.sv
// Randomized bench for rv_mc_ctl: each instruction is scored against a per-instruction
// cost model (cycles, handshakes, enables, counter, trap cause) derived from the ISA rules.
module tb_rv_mc_ctl;

    localparam int MAXW = 15;
    localparam logic [1:0] PC_INC = 2'd0, PC_ALU = 2'd1, PC_ALUOUT = 2'd2, PC_TRAP = 2'd3;
    localparam int K_LW = 0, K_SW = 1, K_ALU = 2, K_BR = 3, K_JAL = 4, K_JALR = 5, K_ILL = 6;

    logic        clk, rst;
    logic [31:0] instr;
    logic        zero, lt;
    logic [1:0]  pcsource, wbsel, asel, bsel, trap_cause;
    logic        pcwrite, pccen, irwrite, mdrwrite, regwen, trap;
    logic [2:0]  immsel;
    logic [3:0]  alusel, state;
    logic [31:0] instr_count;

    logic [31:0] instr2;
    logic [1:0]  pcsource2, wbsel2, asel2, bsel2, trap_cause2;
    logic        pcwrite2, pccen2, irwrite2, mdrwrite2, regwen2, trap2;
    logic [2:0]  immsel2;
    logic [3:0]  alusel2, state2;
    logic [31:0] instr_count2;

    int          checks, errors;
    int          exp_count;
    logic [1:0]  exp_cause;
    logic [63:0] last_hist;

    rv_mc_ctl_if mif();
    rv_mc_ctl_if mif2();

    rv_mc_ctl #(.CNT_W(32), .MEM_WAIT_MAX(MAXW), .TRAP_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .mem(mif), .instr(instr), .zero(zero), .lt(lt),
        .pcsource(pcsource), .pcwrite(pcwrite), .pccen(pccen), .irwrite(irwrite),
        .mdrwrite(mdrwrite), .regwen(regwen), .wbsel(wbsel), .immsel(immsel),
        .asel(asel), .bsel(bsel), .alusel(alusel), .trap(trap), .trap_cause(trap_cause),
        .state(state), .instr_count(instr_count)
    );

    rv_mc_ctl #(.CNT_W(32), .MEM_WAIT_MAX(MAXW), .TRAP_EN(1'b0)) dut_notrap (
        .clk(clk), .rst(rst), .mem(mif2), .instr(instr2), .zero(zero), .lt(lt),
        .pcsource(pcsource2), .pcwrite(pcwrite2), .pccen(pccen2), .irwrite(irwrite2),
        .mdrwrite(mdrwrite2), .regwen(regwen2), .wbsel(wbsel2), .immsel(immsel2),
        .asel(asel2), .bsel(bsel2), .alusel(alusel2), .trap(trap2), .trap_cause(trap_cause2),
        .state(state2), .instr_count(instr_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int kindOf(input logic [31:0] ins);
        case (ins[6:0])
            7'h03:               return K_LW;
            7'h23:               return K_SW;
            7'h33, 7'h13, 7'h37: return K_ALU;
            7'h63:               return K_BR;
            7'h6F:               return K_JAL;
            7'h67:               return K_JALR;
            default:             return K_ILL;
        endcase
    endfunction

    function automatic logic [31:0] makeInstr(input int k);
        logic [31:0] r;
        logic [6:0]  op;
        logic [2:0]  f3;
        r = $urandom;
        case (k)
            0: return {r[31:15], 3'b010, r[11:7], 7'h03};
            1: return {r[31:15], 3'b010, r[11:7], 7'h23};
            2: return {1'b0, r[30], 5'd0, r[24:7], 7'h33};
            3: return {r[31:15], 3'b000, r[11:7], 7'h13};
            4: return {r[31:7], 7'h37};
            5: begin
                f3 = (r[1:0] == 2'd0) ? 3'b000 : (r[1:0] == 2'd1) ? 3'b001 : 3'b100;
                return {r[31:15], f3, r[11:7], 7'h63};
            end
            6: return {r[31:7], 7'h6F};
            7: return {r[31:15], 3'b000, r[11:7], 7'h67};
            default: begin
                op = 7'($urandom);
                while (op inside {7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37})
                    op = 7'($urandom);
                return {r[31:7], op};
            end
        endcase
    endfunction

    // Runs one instruction from FETCH to the next FETCH; memory answers after wf
    // (fetch) / wm (data) not-ready cycles.
    task automatic applyStimulus(input logic [31:0] ins, input int wf, input int wm,
                                 input logic z, input logic l);
        int n_cyc, n_req, n_irw, n_pcw, n_rgw, n_mdw, n_trp, n_rw, acc, wcnt, irw_at, need;
        int e_cyc, e_req, e_pcw, e_rgw, e_mdw, e_trp, e_rw, e_rgs, kind;
        logic [1:0] last_src, e_src;
        logic [3:0] rgw_st, mdw_st;
        bit left, done, taken;
        n_cyc = 0; n_req = 0; n_irw = 0; n_pcw = 0; n_rgw = 0; n_mdw = 0; n_trp = 0; n_rw = 0;
        acc = 0; wcnt = 0; irw_at = -1; last_src = PC_INC; rgw_st = 4'd0; mdw_st = 4'd0;
        left = 1'b0; done = 1'b0;
        instr = ins; zero = z; lt = l; last_hist = '0;
        for (int g = 0; g < 80; g++) begin
            if (left && state == 4'd1) begin
                done = 1'b1;
                break;
            end
            need = (acc == 0) ? wf : wm;
            if (mif.mem_req) mif.mem_ready = (wcnt >= need);
            else             mif.mem_ready = 1'($urandom_range(0, 1));
            #1;
            last_hist = {last_hist[59:0], state};
            if (state != 4'd1) left = 1'b1;
            if (mif.mem_req) n_req++;
            if (mif.memrw) n_rw++;
            if (irwrite) begin n_irw++; irw_at = n_cyc; end
            if (pcwrite) begin n_pcw++; last_src = pcsource; end
            if (regwen) begin n_rgw++; rgw_st = state; end
            if (mdrwrite) begin n_mdw++; mdw_st = state; end
            if (trap) n_trp++;
            if (mif.mem_req) begin
                if (mif.mem_ready) begin acc++; wcnt = 0; end
                else wcnt++;
            end
            n_cyc++;
            @(negedge clk);
        end

        kind = kindOf(ins);
        e_req = 0; e_pcw = 0; e_rgw = 0; e_mdw = 0; e_trp = 0; e_rw = 0; e_rgs = 0;
        e_src = PC_INC;
        if (wf > MAXW) begin
            e_cyc = MAXW + 2; e_req = MAXW + 1; e_pcw = 1; e_trp = 1; e_src = PC_TRAP;
            exp_cause = 2'd2;
        end else begin
            e_cyc = wf + 1; e_req = wf + 1; e_pcw = 1;
            case (kind)
                K_LW, K_SW: begin
                    e_cyc += 2;
                    if (wm > MAXW) begin
                        e_cyc += MAXW + 2; e_req += MAXW + 1; e_pcw++; e_trp = 1;
                        e_src = PC_TRAP; exp_cause = 2'd2;
                        if (kind == K_SW) e_rw = MAXW + 1;
                    end else begin
                        e_cyc += wm + 1; e_req += wm + 1; exp_count++;
                        if (kind == K_LW) begin
                            e_cyc++; e_mdw = 1; e_rgw = 1; e_rgs = 5;
                        end else begin
                            e_rw = wm + 1;
                        end
                    end
                end
                K_ALU: begin
                    e_cyc += 3; e_rgw = 1; e_rgs = 9; exp_count++;
                end
                K_BR: begin
                    e_cyc += 2; exp_count++;
                    case (ins[14:12])
                        3'b000:  taken = z;
                        3'b001:  taken = !z;
                        default: taken = l;
                    endcase
                    if (taken) begin e_pcw++; e_src = PC_ALUOUT; end
                end
                K_JAL, K_JALR: begin
                    e_cyc += 2; e_pcw++; e_rgw = 1; e_src = PC_ALU; exp_count++;
                    e_rgs = (kind == K_JAL) ? 11 : 12;
                end
                default: begin
                    e_cyc += 2; e_pcw++; e_trp = 1; e_src = PC_TRAP; exp_cause = 2'd1;
                end
            endcase
        end

        checkOutput("done", done, 1);
        checkOutput("cycles", n_cyc, e_cyc);
        checkOutput("mem_req_cycles", n_req, e_req);
        checkOutput("memrw_cycles", n_rw, e_rw);
        checkOutput("irwrite", n_irw, (wf > MAXW) ? 0 : 1);
        checkOutput("pcwrite", n_pcw, e_pcw);
        checkOutput("pcsource", last_src, e_src);
        checkOutput("regwen", n_rgw, e_rgw);
        checkOutput("mdrwrite", n_mdw, e_mdw);
        checkOutput("trap", n_trp, e_trp);
        checkOutput("instr_count", instr_count, exp_count);
        checkOutput("trap_cause", trap_cause, exp_cause);
        if (wf <= MAXW) checkOutput("irwrite_cycle", irw_at, wf);
        if (e_rgw > 0) checkOutput("regwen_state", rgw_st, e_rgs);
        if (e_mdw > 0) checkOutput("mdrwrite_state", mdw_st, 4);
    endtask

    initial begin
        logic [63:0] hist2;
        bit          trap2_seen;
        int          k, wf, wm;
        checks = 0; errors = 0; exp_count = 0; exp_cause = 2'd0;
        rst = 1'b1; instr = 32'd0; zero = 1'b0; lt = 1'b0;
        mif.mem_ready = 1'b0; mif2.mem_ready = 1'b1; instr2 = 32'h0000000F;

        #12;
        checkOutput("rst_state", state, 0);
        checkOutput("rst_count", instr_count, 0);
        checkOutput("rst_cause", trap_cause, 0);
        checkOutput("rst_outputs", {mif.mem_req, pcwrite, pccen, irwrite, regwen, mdrwrite, trap}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("first_fetch_state", state, 1);
        checkOutput("first_fetch_req", mif.mem_req, 1);

        $display("[TB] LW x1,4(x0) with memory always ready");
        applyStimulus(32'h00402083, 0, 0, 1'b0, 1'b0);
        checkOutput("lw_state_seq", last_hist, 64'h12345);

        $display("[TB] BNE taken then not taken");
        applyStimulus(32'h00209463, 0, 0, 1'b0, 1'b0);
        checkOutput("bne_state_seq", last_hist, 64'h12A);
        applyStimulus(32'h00209463, 0, 0, 1'b1, 1'b0);

        $display("[TB] ADDI with three fetch wait cycles");
        applyStimulus(32'h00500093, 3, 0, 1'b0, 1'b0);

        $display("[TB] fetch timeout, then illegal opcode 0x0F");
        applyStimulus(32'h00500093, 16, 0, 1'b0, 1'b0);
        applyStimulus(32'h0000000F, 0, 0, 1'b0, 1'b0);
        checkOutput("ill_state_seq", last_hist, 64'h12E);

        $display("[TB] limit-cycle ready and data timeouts");
        applyStimulus(32'h00402083, 15, 15, 1'b0, 1'b0);
        applyStimulus(32'h00112223, 0, 16, 1'b0, 1'b0);

        $display("[TB] reset during LW_MEM wait");
        instr = 32'h00402083; mif.mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        mif.mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("lwmem_wait_state", state, 4);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_state", state, 0);
        checkOutput("midrst_req", mif.mem_req, 0);
        checkOutput("midrst_mdrwrite", mdrwrite, 0);
        checkOutput("midrst_count", instr_count, 0);
        checkOutput("midrst_cause", trap_cause, 0);
        mif.mem_ready = 1'b1;
        @(negedge clk);
        checkOutput("rst_hold_state", state, 0);
        checkOutput("rst_hold_we", {mdrwrite, regwen, pcwrite, irwrite}, 0);
        rst = 1'b0;
        exp_count = 0; exp_cause = 2'd0;
        @(negedge clk);
        checkOutput("post_rst_fetch", state, 1);

        $display("[TB] randomized instruction stream");
        for (int i = 0; i < 150; i++) begin
            k  = $urandom_range(0, 8);
            wf = ($urandom_range(0, 11) == 0) ? $urandom_range(16, 18) : $urandom_range(0, 4);
            wm = ($urandom_range(0, 7) == 0) ? $urandom_range(15, 18) : $urandom_range(0, 4);
            applyStimulus(makeInstr(k), wf, wm, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] TRAP_EN=0 instance skips illegal instructions");
        mif.mem_ready = 1'b1;
        instr2 = 32'h0000000F;
        hist2 = '0; trap2_seen = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            hist2 = {hist2[59:0], state2};
            trap2_seen = trap2_seen | trap2;
        end
        checkOutput("notrap_seq", hist2, 64'h121212);
        checkOutput("notrap_count", instr_count2, 0);
        checkOutput("notrap_trap", trap2_seen, 0);
        @(negedge clk);
        #1;
        checkOutput("notrap_fetch", state2, 1);
        instr2 = 32'h12345037;
        hist2 = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            hist2 = {hist2[59:0], state2};
        end
        checkOutput("notrap_lui_seq", hist2, 64'h2D91);
        checkOutput("notrap_lui_count", instr_count2, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
